dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter FRQ_RST, default 32'd85899346, is the frq_word value after reset (1 MHz at 50 MHz sclk).
REQ-002 Parameter DWELL_W, default 16, is the width of the dwell configuration and counter.
REQ-003 Port sclk, input, 1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port start, input, 1: single-cycle request to begin a sweep.
REQ-006 Port stop, input, 1: single-cycle request to abort a sweep.
REQ-007 Port mode, input, 2: 00 single-up, 01 sawtooth-repeat, 10 triangle-repeat, 11 single-down.
REQ-008 Port f_start, input, 32: lower frequency word.
REQ-009 Port f_stop, input, 32: upper frequency word.
REQ-010 Port f_step, input, 32: increment per dwell period.
REQ-011 Port dwell, input, DWELL_W: sclk cycles per frequency point (0 treated as 1).
REQ-012 Port frq_word, output, 32: frequency word driving the DDS phase accumulator.
REQ-013 Port phase_clr, output, 1: one-cycle pulse telling the accumulator to reload its initial phase.
REQ-014 Port word_upd, output, 1: one-cycle pulse in the cycle frq_word takes a new value.
REQ-015 Ports busy, done, err, output, 1 each: sweep active; one-cycle completion pulse; one-cycle config-reject pulse.

Function
REQ-016 FSM states SHALL be IDLE, RUN_UP, RUN_DN, DONE.
REQ-017 In IDLE, start SHALL latch mode, f_start, f_stop, f_step and dwell into shadow registers; later input changes SHALL NOT affect a running sweep.
REQ-018 start SHALL be rejected (err pulse next cycle, state IDLE, frq_word unchanged) if f_start > f_stop or f_step == 0.
REQ-019 On accepted start, next cycle: frq_word = f_start (f_stop for mode 11), phase_clr = 1, word_upd = 1, busy = 1, state RUN_UP (RUN_DN for mode 11), dwell counter loaded.
REQ-020 Each frequency point SHALL be held exactly max(dwell,1) cycles; at expiry frq_word updates in the following cycle with word_upd = 1.
REQ-021 RUN_UP step: 33-bit sum frq_word + f_step; if sum >= f_stop then frq_word = f_stop (clamped, no wrap) and the clamped point is dwelled normally.
REQ-022 Dwell expiry at f_stop in RUN_UP: mode 00 -> DONE; mode 01 -> frq_word = f_start, phase_clr pulse; mode 10 -> RUN_DN, first down step applied.
REQ-023 RUN_DN step: frq_word - f_step with borrow; if borrow or result <= f_start then frq_word = f_start (clamped).
REQ-024 Dwell expiry at f_start in RUN_DN: mode 11 -> DONE; mode 10 -> RUN_UP, first up step applied.
REQ-025 Entering DONE: done = 1 for one cycle, busy = 0, frq_word held; DONE returns to IDLE next cycle.
REQ-026 stop in RUN_UP/RUN_DN SHALL force IDLE next cycle, busy = 0, frq_word held at last value, no done pulse.
REQ-027 start while busy SHALL be ignored; start and stop in the same cycle: stop wins, start discarded.
REQ-028 f_start == f_stop SHALL be accepted: one point dwelled, then per mode (00/11 done; 01/10 repeat same word).
REQ-029 phase_clr, word_upd, done, err SHALL never be high for more than one consecutive cycle, except phase_clr/word_upd on consecutive sawtooth wraps with dwell 1.

Reset
REQ-030 With rst = 1 at a sclk edge: state IDLE, frq_word = FRQ_RST, shadow registers = 0, dwell counter = 0, all pulse outputs and busy = 0.
REQ-031 rst mid-sweep SHALL override all other inputs and abort without done.

Structure
REQ-032 Package dds_pkg SHALL hold mode encodings, FSM state encoding and FRQ_RST default; shared with the DDS core.
REQ-033 Dwell counter SHALL be sub-module dds_dwell_timer (load, count-down, expire pulse); stepping logic stays in dds_sweep_ctrl.

Verification
REQ-034 mode 00, f_start 100, f_stop 400, f_step 100, dwell 3 -> frq_word 100,200,300,400 each 3 cycles, then done pulse, busy 0.
REQ-035 mode 00, f_start 0, f_stop 250, f_step 100 -> 0,100,200,250 (clamped), done.
REQ-036 mode 10, 100/300, step 100, dwell 1 -> 100,200,300,200,100,200,... until stop; after stop, frq_word frozen.
REQ-037 mode 11, f_start 5, f_stop 0xFFFFFFF0, f_step 0x80000000 -> 0xFFFFFFF0, 0x7FFFFFF0, 5 (borrow clamp), done.
REQ-038 start with f_start 500 > f_stop 100, or f_step 0 -> err pulse, state IDLE, frq_word unchanged.
REQ-039 rst asserted mid-sweep, and start+stop in same cycle -> frq_word = FRQ_RST / no sweep started, respectively.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller and the DDS core.
//   - Frequency-word reset default (1 MHz at 50 MHz sclk)
//   - Sweep mode encodings (mode_e)
//   - Sweep controller FSM state encoding (state_e)
package dds_pkg;

    localparam logic [31:0] FRQ_RST_DEF = 32'd85899346;

    typedef enum logic [1:0] {
        MODE_UP  = 2'b00,   // single sweep upward, then done
        MODE_SAW = 2'b01,   // upward sweep, jump back to f_start, repeat
        MODE_TRI = 2'b10,   // up then down, repeat
        MODE_DN  = 2'b11    // single sweep downward, then done
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN_UP = 2'b01,
        RUN_DN = 2'b10,
        DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell counter for the sweep controller.
// Ports:
//   sclk     : clock (rising edge)
//   rst      : synchronous active-high reset, clears the counter
//   load     : load load_val into the counter
//   clr      : clear the counter (timer idle, no expiry)
//   load_val : cycles per frequency point, must already be >= 1
//   expire   : high during the last cycle of the current dwell period
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               load,
    input  logic               clr,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);

    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [DWELL_W-1:0] cnt_r;

    // Down-counter: a count of 1 marks the final cycle of the dwell period.
    always_ff @(posedge sclk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == CNT_ONE);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep controller feeding a DDS phase accumulator.
// Ports:
//   sclk, rst            : clock, synchronous active-high reset
//   start, stop          : single-cycle sweep begin / abort requests
//   mode                 : 00 up, 01 sawtooth, 10 triangle, 11 down
//   f_start, f_stop      : lower / upper frequency words
//   f_step, dwell        : step per point, cycles per point (0 acts as 1)
//   frq_word             : current frequency word
//   phase_clr, word_upd  : accumulator phase reload / new-word pulses
//   busy, done, err      : sweep active, completion pulse, config reject pulse
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter logic [31:0] FRQ_RST = FRQ_RST_DEF,
    parameter int          DWELL_W = 16
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [31:0]        f_start,
    input  logic [31:0]        f_stop,
    input  logic [31:0]        f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [31:0]        frq_word,
    output logic               phase_clr,
    output logic               word_upd,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [DWELL_W-1:0] DW_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DW_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_e             state_r, state_s;
    mode_e              mode_r, mode_s;
    logic [31:0]        fstart_r, fstart_s, fstop_r, fstop_s, fstep_r, fstep_s;
    logic [DWELL_W-1:0] dwell_r, dwell_s;
    logic [31:0]        frq_r, frq_s;
    logic               busy_s, phase_clr_s, word_upd_s, done_s, err_s;
    logic               tmr_load_s, tmr_clr_s, tmr_expire_s;
    logic [DWELL_W-1:0] tmr_val_s;
    logic [32:0]        sum_s, diff_s;
    logic [31:0]        up_next_s, dn_next_s;

    dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .sclk     (sclk),
        .rst      (rst),
        .load     (tmr_load_s),
        .clr      (tmr_clr_s),
        .load_val (tmr_val_s),
        .expire   (tmr_expire_s)
    );

    // Next up/down points; 33-bit arithmetic so carry/borrow clamp instead of wrapping.
    always_comb begin
        sum_s     = {1'b0, frq_r} + {1'b0, fstep_r};
        diff_s    = {1'b0, frq_r} - {1'b0, fstep_r};
        up_next_s = (sum_s >= {1'b0, fstop_r}) ? fstop_r : sum_s[31:0];
        dn_next_s = (diff_s[32] || (diff_s[31:0] <= fstart_r)) ? fstart_r : diff_s[31:0];
        // Idle loads come straight from the port; running reloads from the shadow copy.
        if (state_r == IDLE) begin
            tmr_val_s = (dwell == DW_ZERO) ? DW_ONE : dwell;
        end else begin
            tmr_val_s = (dwell_r == DW_ZERO) ? DW_ONE : dwell_r;
        end
    end

    // Sweep FSM next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        fstart_s    = fstart_r;
        fstop_s     = fstop_r;
        fstep_s     = fstep_r;
        dwell_s     = dwell_r;
        frq_s       = frq_r;
        busy_s      = busy_r_q();
        phase_clr_s = 1'b0;
        word_upd_s  = 1'b0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_clr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (stop) begin
                    tmr_clr_s = 1'b1;       // stop beats a simultaneous start
                end else if (start) begin
                    if ((f_start > f_stop) || (f_step == 32'd0)) begin
                        err_s = 1'b1;
                    end else begin
                        mode_s      = mode_e'(mode);
                        fstart_s    = f_start;
                        fstop_s     = f_stop;
                        fstep_s     = f_step;
                        dwell_s     = dwell;
                        busy_s      = 1'b1;
                        phase_clr_s = 1'b1;
                        word_upd_s  = 1'b1;
                        tmr_load_s  = 1'b1;
                        if (mode_e'(mode) == MODE_DN) begin
                            frq_s   = f_stop;
                            state_s = RUN_DN;
                        end else begin
                            frq_s   = f_start;
                            state_s = RUN_UP;
                        end
                    end
                end else begin
                    tmr_clr_s = 1'b0;
                end
            end
            RUN_UP: begin
                if (stop) begin
                    state_s   = IDLE;
                    busy_s    = 1'b0;
                    tmr_clr_s = 1'b1;
                end else if (tmr_expire_s) begin
                    if (frq_r == fstop_r) begin
                        case (mode_r)
                            MODE_SAW: begin
                                frq_s       = fstart_r;
                                phase_clr_s = 1'b1;
                                word_upd_s  = 1'b1;
                                tmr_load_s  = 1'b1;
                            end
                            MODE_TRI: begin
                                frq_s      = dn_next_s;
                                word_upd_s = 1'b1;
                                tmr_load_s = 1'b1;
                                state_s    = RUN_DN;
                            end
                            default: begin
                                state_s   = DONE;
                                done_s    = 1'b1;
                                busy_s    = 1'b0;
                                tmr_clr_s = 1'b1;
                            end
                        endcase
                    end else begin
                        frq_s      = up_next_s;
                        word_upd_s = 1'b1;
                        tmr_load_s = 1'b1;
                    end
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            RUN_DN: begin
                if (stop) begin
                    state_s   = IDLE;
                    busy_s    = 1'b0;
                    tmr_clr_s = 1'b1;
                end else if (tmr_expire_s) begin
                    if (frq_r == fstart_r) begin
                        if (mode_r == MODE_TRI) begin
                            frq_s      = up_next_s;
                            word_upd_s = 1'b1;
                            tmr_load_s = 1'b1;
                            state_s    = RUN_UP;
                        end else begin
                            state_s   = DONE;
                            done_s    = 1'b1;
                            busy_s    = 1'b0;
                            tmr_clr_s = 1'b1;
                        end
                    end else begin
                        frq_s      = dn_next_s;
                        word_upd_s = 1'b1;
                        tmr_load_s = 1'b1;
                    end
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            DONE: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s   = IDLE;
                busy_s    = 1'b0;
                tmr_clr_s = 1'b1;
            end
        endcase
    end

    function automatic logic busy_r_q();
        return busy;
    endfunction

    // State, shadow configuration and registered outputs.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_r   <= IDLE;
            mode_r    <= MODE_UP;
            fstart_r  <= 32'd0;
            fstop_r   <= 32'd0;
            fstep_r   <= 32'd0;
            dwell_r   <= DW_ZERO;
            frq_r     <= FRQ_RST;
            busy      <= 1'b0;
            phase_clr <= 1'b0;
            word_upd  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= state_s;
            mode_r    <= mode_s;
            fstart_r  <= fstart_s;
            fstop_r   <= fstop_s;
            fstep_r   <= fstep_s;
            dwell_r   <= dwell_s;
            frq_r     <= frq_s;
            busy      <= busy_s;
            phase_clr <= phase_clr_s;
            word_upd  <= word_upd_s;
            done      <= done_s;
            err       <= err_s;
        end
    end

    assign frq_word = frq_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table of single sweeps / rejects,
// followed by hand-written triangle+stop, sawtooth+ignored start+reset and
// start+stop sequences.
module tb_dds_sweep_ctrl;

    localparam logic [31:0] EXP_RST = 32'd85899346;

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] f_start = 32'd0;
    logic [31:0] f_stop = 32'd0;
    logic [31:0] f_step = 32'd0;
    logic [15:0] dwell = 16'd0;
    logic [31:0] frq_word;
    logic        phase_clr, word_upd, busy, done, err;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    dds_sweep_ctrl dut (
        .sclk(sclk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .frq_word(frq_word), .phase_clr(phase_clr), .word_upd(word_upd),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [1:0]       mode;
        logic [31:0]      fs;
        logic [31:0]      fe;
        logic [31:0]      st;
        logic [15:0]      dw;
        int               npts;
        logic [5:0][31:0] w;     // expected points, w[0] first
        bit               rej;
    } vec_t;

    vec_t vecs [0:6];
    logic [31:0] last_frq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   d;
        v = vecs[idx];
        d = (v.dw == 16'd0) ? 1 : int'(v.dw);
        mode = v.mode; f_start = v.fs; f_stop = v.fe; f_step = v.st; dwell = v.dw;
        start = 1'b1;
        step();
        start = 1'b0;
        if (v.rej) begin
            chk("err_pulse", err, 1'b1);
            chk("err_busy", busy, 1'b0);
            chk("err_frq", frq_word, last_frq);
            chk("err_wupd", word_upd, 1'b0);
            step();
            chk("err_single", err, 1'b0);
            chk("err_frq2", frq_word, last_frq);
        end else begin
            // scramble the ports: the running sweep must use its latched copy
            mode = ~v.mode; f_start = 32'h1234; f_stop = 32'h5; f_step = 32'd7; dwell = 16'd9;
            for (int p = 0; p < v.npts; p++) begin
                for (int c = 0; c < d; c++) begin
                    chk("sweep_frq", frq_word, v.w[p]);
                    chk("sweep_wupd", word_upd, (c == 0));
                    chk("sweep_pclr", phase_clr, (p == 0 && c == 0));
                    chk("sweep_busy", busy, 1'b1);
                    chk("sweep_done", done, 1'b0);
                    step();
                end
            end
            chk("done_pulse", done, 1'b1);
            chk("done_busy", busy, 1'b0);
            chk("done_frq", frq_word, v.w[v.npts-1]);
            chk("done_wupd", word_upd, 1'b0);
            step();
            chk("done_single", done, 1'b0);
            chk("done_idle_busy", busy, 1'b0);
            chk("done_hold_frq", frq_word, v.w[v.npts-1]);
            last_frq = v.w[v.npts-1];
        end
    endtask

    logic [31:0] tri_w [0:5];
    logic [31:0] saw_w [0:4];
    logic        saw_p [0:4];

    initial begin
        vecs[0] = '{2'b00, 32'd100, 32'd400, 32'd100, 16'd3, 4,
                    {32'd0, 32'd0, 32'd400, 32'd300, 32'd200, 32'd100}, 1'b0};
        vecs[1] = '{2'b00, 32'd0, 32'd250, 32'd100, 16'd2, 4,
                    {32'd0, 32'd0, 32'd250, 32'd200, 32'd100, 32'd0}, 1'b0};
        vecs[2] = '{2'b11, 32'd5, 32'hFFFFFFF0, 32'h80000000, 16'd1, 3,
                    {32'd0, 32'd0, 32'd0, 32'd5, 32'h7FFFFFF0, 32'hFFFFFFF0}, 1'b0};
        vecs[3] = '{2'b00, 32'd500, 32'd100, 32'd10, 16'd1, 0,
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b1};
        vecs[4] = '{2'b00, 32'd100, 32'd200, 32'd0, 16'd1, 0,
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b1};
        vecs[5] = '{2'b00, 32'd77, 32'd77, 32'd5, 16'd0, 1,
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd77}, 1'b0};
        vecs[6] = '{2'b11, 32'd10, 32'd40, 32'd15, 16'd2, 3,
                    {32'd0, 32'd0, 32'd0, 32'd10, 32'd25, 32'd40}, 1'b0};
        tri_w = '{32'd100, 32'd200, 32'd300, 32'd200, 32'd100, 32'd200};
        saw_w = '{32'd10, 32'd20, 32'd30, 32'd10, 32'd20};
        saw_p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // reset state
        step();
        step();
        chk("rst_frq", frq_word, EXP_RST);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pulses", {phase_clr, word_upd, done, err}, 4'b0000);
        rst = 1'b0;
        step();
        chk("rst_release_frq", frq_word, EXP_RST);
        last_frq = EXP_RST;

        // an error before any sweep keeps the reset word
        run_vec(3);
        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        // triangle, dwell 1, aborted by stop
        mode = 2'b10; f_start = 32'd100; f_stop = 32'd300; f_step = 32'd100; dwell = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("tri_frq", frq_word, tri_w[i]);
            chk("tri_wupd", word_upd, 1'b1);
            chk("tri_pclr", phase_clr, (i == 0));
            chk("tri_busy", busy, 1'b1);
            if (i < 5) begin
                step();
            end else begin
                stop = 1'b1;
                step();
                stop = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk("stop_frq", frq_word, 32'd200);
            chk("stop_busy", busy, 1'b0);
            chk("stop_nodone", done, 1'b0);
            chk("stop_wupd", word_upd, 1'b0);
            step();
        end

        // sawtooth, dwell 1; a start mid-sweep is ignored; rst aborts
        mode = 2'b01; f_start = 32'd10; f_stop = 32'd30; f_step = 32'd10; dwell = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("saw_frq", frq_word, saw_w[i]);
            chk("saw_pclr", phase_clr, saw_p[i]);
            chk("saw_wupd", word_upd, 1'b1);
            chk("saw_busy", busy, 1'b1);
            if (i == 1) begin
                start = 1'b1; mode = 2'b11; f_start = 32'd0; f_stop = 32'd999;
            end else begin
                start = 1'b0;
            end
            if (i < 4) begin
                step();
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_frq", frq_word, EXP_RST);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_wupd", word_upd, 1'b0);
        step();
        chk("midrst_frq2", frq_word, EXP_RST);
        chk("midrst_done2", done, 1'b0);

        // start and stop together: no sweep
        mode = 2'b00; f_start = 32'd1; f_stop = 32'd50; f_step = 32'd1; dwell = 16'd1;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ss_busy", busy, 1'b0);
            chk("ss_frq", frq_word, EXP_RST);
            chk("ss_wupd", word_upd, 1'b0);
            chk("ss_err", err, 1'b0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
